// File: rtl/fifo_fwft_out_if.sv
// Output stream of the FWFT read stage: one word per rising edge where
// m_valid && m_ready; m_valid/m_data stay stable while m_valid && !m_ready.
interface fifo_fwft_out_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        output m_data,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/fifo_fwft_out.sv
// Read-side first-word-fall-through stage: turns rd_en/empty/next-cycle RAM data
// into a valid/ready stream through a two-entry head+skid buffer.
module fifo_fwft_out #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    fifo_fwft_out_if.master       m_if,
    output logic [1:0]            buf_cnt
);
    logic                  en_q;
    logic                  inflight;
    logic                  head_valid;
    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] head_data;
    logic [DATA_WIDTH-1:0] skid_data;
    logic                  pop;
    logic [2:0]            occ_next;

    assign pop          = head_valid && m_if.m_ready;
    assign buf_cnt      = {1'b0, head_valid} + {1'b0, skid_valid};
    assign m_if.m_valid = head_valid;
    assign m_if.m_data  = head_data;

    // Occupancy once the in-flight word lands and this cycle's pop leaves;
    // a new read is only allowed if its word will still find a free slot.
    assign occ_next   = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign fifo_rd_en = en_q && !fifo_empty && (occ_next <= 3'd1);

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            en_q     <= 1'b0;
            inflight <= 1'b0;
        end else begin
            en_q     <= 1'b1;
            inflight <= fifo_rd_en;
        end
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            head_valid <= 1'b0;
            head_data  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (pop && !inflight) begin
            if (skid_valid) begin
                head_data  <= skid_data;
                skid_valid <= 1'b0;
            end else begin
                head_valid <= 1'b0;
            end
        end else if (inflight && !pop) begin
            if (!head_valid) begin
                head_data  <= fifo_dout;
                head_valid <= 1'b1;
            end else begin
                skid_data  <= fifo_dout;
                skid_valid <= 1'b1;
            end
        end else if (inflight && pop) begin
            // Buffer level is unchanged; the arriving word queues behind the skid word.
            if (skid_valid) begin
                head_data <= skid_data;
                skid_data <= fifo_dout;
            end else begin
                head_data <= fifo_dout;
            end
        end
    end
endmodule

// File: doc/fifo_fwft_out.md
Name: fifo_fwft_out

Overview:
- Read-side output stage of the async FIFO. Sits directly downstream of the read-pointer controller and the dual-port RAM read port, in the rd_clk domain.
- Converts the standard-read interface into a first-word-fall-through valid/ready stream:
  - the standard-read interface is rd_en, a registered empty flag, and RAM data one cycle after rd_en;
  - the output stream has m_valid, m_data and m_ready.
- A two-entry skid buffer sustains one word per cycle under continuous m_ready.

Parameters:
DATA_WIDTH, 8, width of one FIFO word (matches the 8-bit x 256 RAM)

Ports:
rd_clk      input   1           read-domain clock
rd_rst_n    input   1           asynchronous active-low reset
fifo_empty  input   1           registered empty flag from the read controller; reflects any read issued in the previous cycle
fifo_rd_en  output  1           read request to the read controller and RAM; never high while fifo_empty is high
fifo_dout   input   DATA_WIDTH  RAM read data; valid in the cycle after fifo_rd_en
m_data      output  DATA_WIDTH  output word
m_valid     output  1           m_data holds a valid word
m_ready     input   1           consumer accepts; a transfer occurs when m_valid && m_ready at a rising edge
buf_cnt     output  2           number of words held (0..2)

Behaviour:
- Clock and reset: one clock, rd_clk. rd_rst_n is asynchronous and active-low.
- Reset values: m_valid=0, m_data=0, buf_cnt=0. Internal skid_valid=0, skid_data=0, inflight=0, en_q=0.
- en_q is a flop set to 1 on the first rd_clk edge after reset release. fifo_rd_en stays 0 while en_q=0, so no read is issued during reset or in the first cycle after release.
- Storage:
  - head register drives m_data/m_valid;
  - skid register holds the second word;
  - buf_cnt = m_valid + skid_valid.
- inflight is a flop equal to the previous cycle's fifo_rd_en; it means fifo_dout is valid this cycle.
- pop = m_valid && m_ready.
- Issue rule (combinational): fifo_rd_en = en_q && !fifo_empty && (buf_cnt + inflight - pop) <= 1.
  - Guarantees buf_cnt never exceeds 2 and no arriving word is ever dropped.
- Per rising edge, priority order:
  - pop, no arrival:
    - skid_valid → head<=skid, skid_valid<=0;
    - else m_valid<=0.
  - arrival (inflight), no pop:
    - !m_valid → head<=fifo_dout, m_valid<=1;
    - else skid<=fifo_dout, skid_valid<=1.
  - arrival and pop together:
    - skid_valid → head<=skid, skid<=fifo_dout;
    - else head<=fifo_dout, m_valid stays 1.
  - neither: hold.
- Latency: fifo_rd_en high in cycle N → fifo_dout valid in N+1 → m_valid=1 with that word from cycle N+2 (if the buffer was empty).
- Throughput: with m_ready held 1 and FIFO non-empty, fifo_rd_en stays 1 every cycle and one word transfers per cycle.
- Stream rule: while m_valid=1 and m_ready=0, m_data and m_valid hold stable.
- Ordering: words leave in exactly the order read from the RAM.
- Empty boundary: fifo_empty=1 → no new reads. Words already in flight or buffered still drain normally.
- Full boundary: buf_cnt=2 with m_ready=0 → fifo_rd_en=0 regardless of fifo_empty.
- Reset mid-operation: all buffered and in-flight words are discarded immediately (asynchronous). The read controller is reset on the same rd_rst_n.
- Illegal condition (bench assertion): inflight=1 while buf_cnt=2 and pop=0. This is unreachable by construction.

Test Plan:
- Reset release with fifo_empty=1 → fifo_rd_en, m_valid and buf_cnt stay 0 indefinitely; m_data=0.
- FIFO holds 0x11,0x22,0x33 and m_ready=1 → fifo_rd_en high for 3 consecutive cycles starting the cycle after en_q sets; m_valid on 3 consecutive cycles with m_data 0x11, 0x22, 0x33; then m_valid=0.
- FIFO holds 0xA0..0xA4 and m_ready=0 → exactly 2 reads issued, buf_cnt=2, m_data=0xA0 stable. Raise m_ready → 0xA0..0xA4 delivered in order with no gaps after the first.
- m_ready toggling 1,0,1,0 with 8 words queued → all 8 words delivered in order; buf_cnt never 3; fifo_rd_en never high while fifo_empty=1.
- rd_rst_n pulsed low while buf_cnt=2 and a read is in flight → m_valid=0 and buf_cnt=0 immediately; after re-release, first output word is the first word written after reset.
- Single word written into an empty FIFO → m_valid rises exactly 2 cycles after fifo_rd_en, then stays high until m_ready=1.
